// File: rtl/expr_paren_checker_pkg.sv
// Shared encodings for the serial expression recognisers: state, character class, ASCII.
// Pure declarations; no timing, no flow control.
package expr_pkg;

    typedef enum logic [1:0] {
        EXPECT = 2'b00,
        NUM    = 2'b01,
        CLOSE  = 2'b10,
        DEAD   = 2'b11
    } state_e;

    typedef enum logic [2:0] {
        DIG = 3'd0,
        OP  = 3'd1,
        LP  = 3'd2,
        RP  = 3'd3,
        OTH = 3'd4
    } cls_e;

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_STAR  = 8'h2A;
    localparam logic [7:0] CH_SLASH = 8'h2F;
    localparam logic [7:0] CH_LP    = 8'h28;
    localparam logic [7:0] CH_RP    = 8'h29;

    // Operator-mask bit positions.
    localparam int OPB_PLUS  = 0;
    localparam int OPB_MINUS = 1;
    localparam int OPB_STAR  = 2;
    localparam int OPB_SLASH = 3;

    function automatic logic is_digit(input logic [7:0] ch);
        return (ch >= CH_0) && (ch <= CH_9);
    endfunction

endpackage

// File: rtl/expr_paren_checker_if.sv
// Character stream in, recogniser status out; master drives characters, slave is the checker.
// No backpressure: every strobed character is consumed.
interface expr_paren_checker_if #(
    parameter int DEPTH_W = 3,
    parameter int LEN_W   = 8
);
    logic               in_valid;
    logic [7:0]         in;
    logic               out;
    logic               dead;
    logic [DEPTH_W-1:0] depth;
    logic [LEN_W-1:0]   len;

    modport master (
        output in_valid,
        output in,
        input  out,
        input  dead,
        input  depth,
        input  len
    );

    modport slave (
        input  in_valid,
        input  in,
        output out,
        output dead,
        output depth,
        output len
    );
endinterface

// File: rtl/expr_paren_checker_char_class.sv
// Combinational ASCII classifier; operators whose mask bit is clear are treated as OTH.
// Zero latency, no flow control.
module expr_char_class
    import expr_pkg::*;
(
    input  logic [7:0] ch_i,
    input  logic [3:0] op_mask_i,
    output cls_e       cls_o
);

    always_comb begin
        cls_o = OTH;
        if (is_digit(ch_i)) begin
            cls_o = DIG;
        end else begin
            unique case (ch_i)
                CH_LP:    cls_o = LP;
                CH_RP:    cls_o = RP;
                CH_PLUS:  cls_o = op_mask_i[OPB_PLUS]  ? OP : OTH;
                CH_MINUS: cls_o = op_mask_i[OPB_MINUS] ? OP : OTH;
                CH_STAR:  cls_o = op_mask_i[OPB_STAR]  ? OP : OTH;
                CH_SLASH: cls_o = op_mask_i[OPB_SLASH] ? OP : OTH;
                default:  cls_o = OTH;
            endcase
        end
    end

endmodule

// File: rtl/expr_paren_checker.sv
// Moore recogniser for parenthesised +-*/ expressions; outputs reflect a character one cycle after it is consumed.
// No backpressure: every in_valid cycle consumes a character, DEAD absorbs until clr.
module expr_paren_checker
    import expr_pkg::*;
#(
    parameter int         DEPTH_W    = 3,
    parameter logic [3:0] OP_MASK    = 4'b0101,
    parameter bit         MULTIDIGIT = 1'b0,
    parameter int         LEN_W      = 8
) (
    input  logic                 clk,
    input  logic                 clr,
    expr_paren_checker_if.slave  bus
);

    localparam logic [DEPTH_W-1:0] MAXD    = '1;
    localparam logic [LEN_W-1:0]   LEN_MAX = '1;

    state_e             state_q, state_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic [LEN_W-1:0]   len_q,   len_d;
    cls_e               cls;

    expr_char_class u_class (
        .ch_i      (bus.in),
        .op_mask_i (OP_MASK),
        .cls_o     (cls)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= EXPECT;
            depth_q <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        len_d   = len_q;
        if (bus.in_valid) begin
            if (len_q != LEN_MAX) begin
                len_d = len_q + 1'b1;
            end
            unique case (state_q)
                EXPECT: begin
                    if (cls == DIG) begin
                        state_d = NUM;
                    end else if (cls == LP && depth_q != MAXD) begin
                        depth_d = depth_q + 1'b1;
                    end else begin
                        state_d = DEAD;
                    end
                end
                NUM, CLOSE: begin
                    // A closing paren is legal after an operand or another ')', given something is open.
                    if (cls == OP) begin
                        state_d = EXPECT;
                    end else if (cls == RP && depth_q != '0) begin
                        state_d = CLOSE;
                        depth_d = depth_q - 1'b1;
                    end else if (cls == DIG && state_q == NUM && MULTIDIGIT) begin
                        state_d = NUM;
                    end else begin
                        state_d = DEAD;
                    end
                end
                DEAD: begin
                    state_d = DEAD;
                end
                default: begin
                    state_d = DEAD;
                end
            endcase
        end
    end

    assign bus.out   = ((state_q == NUM) || (state_q == CLOSE)) && (depth_q == '0);
    assign bus.dead  = (state_q == DEAD);
    assign bus.depth = depth_q;
    assign bus.len   = len_q;

endmodule

// File: tb/tb_expr_paren_checker.sv
// Four configurations of the recogniser fed the same character stream, each checked against a prefix-scanning reference.
module tb_expr_paren_checker;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       vld = 1'b0;
    logic [7:0] din = 8'h00;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] hist[$];

    // cfg 0 defaults, 1 multidigit, 2 all operators, 3 shallow depth / short length counter
    int cfg_mask[4] = '{4'b0101, 4'b0101, 4'b1111, 4'b0101};
    int cfg_md[4]   = '{0, 1, 0, 0};
    int cfg_maxd[4] = '{7, 7, 7, 3};
    int cfg_lmax[4] = '{255, 255, 255, 15};

    always #5 clk = ~clk;

    expr_paren_checker_if #(.DEPTH_W(3), .LEN_W(8)) if0 ();
    expr_paren_checker_if #(.DEPTH_W(3), .LEN_W(8)) if1 ();
    expr_paren_checker_if #(.DEPTH_W(3), .LEN_W(8)) if2 ();
    expr_paren_checker_if #(.DEPTH_W(2), .LEN_W(4)) if3 ();

    assign if0.in_valid = vld; assign if0.in = din;
    assign if1.in_valid = vld; assign if1.in = din;
    assign if2.in_valid = vld; assign if2.in = din;
    assign if3.in_valid = vld; assign if3.in = din;

    expr_paren_checker #(.DEPTH_W(3), .OP_MASK(4'b0101), .MULTIDIGIT(1'b0), .LEN_W(8))
        u_dut0 (.clk(clk), .clr(clr), .bus(if0));
    expr_paren_checker #(.DEPTH_W(3), .OP_MASK(4'b0101), .MULTIDIGIT(1'b1), .LEN_W(8))
        u_dut1 (.clk(clk), .clr(clr), .bus(if1));
    expr_paren_checker #(.DEPTH_W(3), .OP_MASK(4'b1111), .MULTIDIGIT(1'b0), .LEN_W(8))
        u_dut2 (.clk(clk), .clr(clr), .bus(if2));
    expr_paren_checker #(.DEPTH_W(2), .OP_MASK(4'b0101), .MULTIDIGIT(1'b0), .LEN_W(4))
        u_dut3 (.clk(clk), .clr(clr), .bus(if3));

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Rescans the whole prefix: kind 0 = operand needed, 1 = just had a digit, 2 = just had ')'.
    function automatic void ref_eval(input logic [7:0] h[$], input int mask, input int md,
                                     input int maxd, output bit o, output bit d, output int dp);
        int lvl  = 0;
        int kind = 0;
        d = 1'b0;
        foreach (h[i]) begin
            logic [7:0] c = h[i];
            bit isdig = (c >= "0") && (c <= "9");
            bit isop  = (c == "+" && mask[0]) || (c == "-" && mask[1]) ||
                        (c == "*" && mask[2]) || (c == "/" && mask[3]);
            if (isdig) begin
                if (kind == 2 || (kind == 1 && md == 0)) begin d = 1'b1; break; end
                kind = 1;
            end else if (isop) begin
                if (kind == 0) begin d = 1'b1; break; end
                kind = 0;
            end else if (c == "(") begin
                if (kind != 0 || lvl == maxd) begin d = 1'b1; break; end
                lvl++;
            end else if (c == ")") begin
                if (kind == 0 || lvl == 0) begin d = 1'b1; break; end
                lvl--;
                kind = 2;
            end else begin
                d = 1'b1;
                break;
            end
        end
        o  = !d && kind != 0 && lvl == 0;
        dp = lvl;
    endfunction

    task automatic check_cfg(input string tag, input int k, input int g_o, input int g_d,
                             input int g_dp, input int g_len);
        bit o;
        bit d;
        int dp;
        int ln;
        ref_eval(hist, cfg_mask[k], cfg_md[k], cfg_maxd[k], o, d, dp);
        ln = (hist.size() > cfg_lmax[k]) ? cfg_lmax[k] : hist.size();
        chk($sformatf("%s.c%0d.out", tag, k),   g_o,   int'(o));
        chk($sformatf("%s.c%0d.dead", tag, k),  g_d,   int'(d));
        chk($sformatf("%s.c%0d.depth", tag, k), g_dp,  dp);
        chk($sformatf("%s.c%0d.len", tag, k),   g_len, ln);
    endtask

    task automatic check_all(input string tag);
        check_cfg(tag, 0, int'(if0.out), int'(if0.dead), int'(if0.depth), int'(if0.len));
        check_cfg(tag, 1, int'(if1.out), int'(if1.dead), int'(if1.depth), int'(if1.len));
        check_cfg(tag, 2, int'(if2.out), int'(if2.dead), int'(if2.depth), int'(if2.len));
        check_cfg(tag, 3, int'(if3.out), int'(if3.dead), int'(if3.depth), int'(if3.len));
    endtask

    task automatic send(input logic [7:0] c, input bit v, input string tag);
        @(negedge clk);
        din = c;
        vld = v;
        @(posedge clk);
        #1;
        vld = 1'b0;
        if (v) hist.push_back(c);
        check_all(tag);
    endtask

    task automatic send_str(input string s, input string tag);
        for (int i = 0; i < s.len(); i++) send(s[i], 1'b1, tag);
    endtask

    // Reset is checked before any clock edge (asynchronous) and again while held with a live strobe.
    task automatic do_clr(input string tag);
        @(negedge clk);
        clr = 1'b1;
        #1;
        hist.delete();
        check_all({tag, ".async"});
        din = "1";
        vld = 1'b1;
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        @(negedge clk);
        clr = 1'b0;
        vld = 1'b0;
    endtask

    initial begin
        string s;
        int    exp_tp1[5] = '{1, 0, 1, 0, 1};
        int    exp_tp2[9] = '{1, 1, 1, 2, 2, 1, 0, 0, 0};
        logic [7:0] alpha[16] = '{"0", "1", "5", "9", "+", "-", "*", "/",
                                  "(", "(", ")", ")", "2", "7", "(", ")"};

        #1;
        check_all("reset");
        do_clr("init");

        s = "1+2*3";
        for (int i = 0; i < 5; i++) begin
            send(s[i], 1'b1, "tp1");
            chk("tp1.out_seq", int'(if0.out), exp_tp1[i]);
        end
        chk("tp1.len", int'(if0.len), 5);

        do_clr("tp2");
        s = "(1+(2))*3";
        for (int i = 0; i < 9; i++) begin
            send(s[i], 1'b1, "tp2");
            chk("tp2.depth_seq", int'(if0.depth), exp_tp2[i]);
        end

        do_clr("tp3a"); send_str("12", "tp3a");
        chk("tp3a.dead", int'(if0.dead), 1);
        do_clr("tp3b"); send_str("12+345", "tp3b");
        chk("tp3b.md_out", int'(if1.out), 1);

        do_clr("tp4a"); send_str("+1", "tp4a");
        do_clr("tp4b"); send_str("()", "tp4b");
        do_clr("tp4c"); send_str("1)", "tp4c");
        do_clr("tp4d"); send_str("1-2", "tp4d");
        chk("tp4d.dead", int'(if0.dead), 1);
        do_clr("tp4e"); send_str("1-2/3", "tp4e");
        chk("tp4e.allops_out", int'(if2.out), 1);

        do_clr("tp5"); send_str("(((", "tp5");
        chk("tp5.depth3", int'(if3.depth), 3);
        send("(", 1'b1, "tp5");
        chk("tp5.dead", int'(if3.dead), 1);
        chk("tp5.depth_frozen", int'(if3.depth), 3);
        do_clr("tp5.clr");

        send_str("1+", "tp6");
        for (int i = 0; i < 5; i++) send("9", 1'b0, "tp6.idle");
        send("2", 1'b1, "tp6");
        chk("tp6.out", int'(if0.out), 1);
        do_clr("tp6b"); send_str("(1+", "tp6b");
        do_clr("tp6b.mid");
        send("7", 1'b1, "tp6b");
        chk("tp6b.out", int'(if0.out), 1);
        chk("tp6b.len", int'(if0.len), 1);

        // Random mix of legal-ish characters, idle cycles and aborts.
        for (int n = 0; n < 800; n++) begin
            int r = $urandom_range(0, 99);
            if (r < 5) begin
                do_clr("rnd");
            end else begin
                logic [7:0] c = (r < 12) ? 8'($urandom) : alpha[$urandom_range(0, 15)];
                send(c, $urandom_range(0, 4) != 0, "rnd");
            end
        end

        // Long uninterrupted run drives every length counter into saturation.
        do_clr("sat");
        for (int n = 0; n < 270; n++) send(alpha[$urandom_range(0, 15)], 1'b1, "sat");
        chk("sat.len8", int'(if0.len), 255);
        chk("sat.len4", int'(if3.len), 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/expr_paren_checker.md
Name: expr_paren_checker

Overview:
- Moore-style serial recogniser for arithmetic expressions, fed one ASCII character per accepted cycle; successor of the single-digit +/* recogniser.
- Adds parenthesis nesting with a depth counter, optional multi-digit operands, a configurable operator set, an input-valid qualifier, and status outputs (dead, depth, length).
- Sits between the character source (UART/testbench stream) and the control logic that samples `out` after each character.

Parameters:
- DEPTH_W, 3, width of nesting counter; maximum nesting depth MAXD = 2^DEPTH_W - 1.
- OP_MASK, 4'b0101, enabled operators: bit0 '+' (8'h2B), bit1 '-' (8'h2D), bit2 '*' (8'h2A), bit3 '/' (8'h2F).
- MULTIDIGIT, 0, 1 = consecutive digits form one operand; 0 = a digit directly after a digit is illegal.
- LEN_W, 8, width of the accepted-character counter.

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  reset, asynchronous, active-high.
- in_valid  in  1  character strobe; `in` is consumed only on a rising clk edge with in_valid=1.
- in  in  8  ASCII character.
- out  out  1  current prefix is a complete legal expression.
- dead  out  1  prefix is irrecoverably illegal.
- depth  out  DEPTH_W  current count of open parentheses.
- len  out  LEN_W  characters consumed since clr, saturating at 2^LEN_W-1.

Behaviour:
- Reset: clr=1 forces state=EXPECT, depth=0, len=0, so out=0 and dead=0. This holds both on clr assertion and while clr is held. clr has priority over in_valid.
- in_valid=0: all registers hold their values.
- Character classes:
  - DIG: 8'h30..8'h39.
  - OP: one of the four operators whose OP_MASK bit is 1. A masked-off operator is OTH.
  - LP: 8'h28. RP: 8'h29.
  - OTH: everything else.
- States (2-bit): EXPECT (operand required), NUM (last was digit), CLOSE (last was ')'), DEAD.
- EXPECT transitions:
  - DIG -> NUM.
  - LP with depth<MAXD -> depth+1, stay EXPECT.
  - LP with depth==MAXD -> DEAD, depth unchanged.
  - RP, OP, OTH -> DEAD. This makes "()" illegal and a leading operator illegal.
- NUM transitions:
  - DIG -> NUM if MULTIDIGIT=1, else DEAD.
  - OP -> EXPECT.
  - RP with depth>0 -> depth-1, go to CLOSE.
  - RP with depth==0 -> DEAD.
  - LP, OTH -> DEAD.
- CLOSE transitions:
  - OP -> EXPECT.
  - RP: same rule as from NUM.
  - DIG, LP, OTH -> DEAD.
- DEAD: absorbing; only clr leaves it. depth freezes on entry to DEAD.
- out = (state==NUM || state==CLOSE) && depth==0. All outputs are pure functions of registers, so a character's effect is visible the cycle after the edge that consumes it (latency 1).
- len increments on every consumed character, including in DEAD, and saturates (no wrap).
- clr asserted mid-expression aborts it immediately. The next consumed character after clr deasserts is treated as the first character.

Decomposition:
- Package expr_pkg holds:
  - state encoding constants: EXPECT=2'b00, NUM=2'b01, CLOSE=2'b10, DEAD=2'b11;
  - class encoding constants: DIG, OP, LP, RP, OTH (3-bit);
  - ASCII constants for the digits, the four operators, '(' and ')'.
- Sub-module expr_char_class: purely combinational, in[7:0] + OP_MASK -> class[2:0]. It is shared with future expression blocks.
- The top module holds the state, depth and len registers.

Test Plan:
1. Defaults; feed "1+2*3" one char per cycle -> out after each char = 1,0,1,0,1; dead stays 0; len=5.
2. Defaults; "(1+(2))*3" -> depth sequence 1,1,1,2,2,1,0,0,0; out=1 only after ')' #2 (depth 0), 0 after '*', 1 after '3'.
3. Defaults; "12" -> out=1 then dead=1, out=0. With MULTIDIGIT=1, "12+345" -> out=1,1,0,1,1,1, dead=0.
4. Illegal cases, each after clr:
   - "+1" -> dead=1 after first char.
   - "()" -> dead after ')'.
   - "1)" -> dead.
   - "1-2" with default mask -> dead after '-'.
   - OP_MASK=4'b1111, "1-2/3" -> out=1 at end.
5. DEPTH_W=2 (MAXD=3): "(((" -> depth=3; 4th '(' -> dead=1, depth stays 3. Then clr -> depth=0, dead=0, out=0.
6. "1+" with in_valid=0 for 5 cycles, then '2' with in_valid=1 -> state held during the idle cycles, out=1 after '2'. Assert clr mid-way through "(1+" -> all zero; then "7" -> out=1, len=1.
